// File: rtl/mmio_gpio.sv
// rtl/mmio_gpio.sv - memory-mapped GPIO peripheral (switches, debounced buttons, LEDs, irq)
//
// Word-addressed register block on the data bus, decoded in a 32-byte window at BASE_ADDR.
// Optional feature macro: GPIO_LED_TOGGLE_EN (enables the LED_TOGGLE register at offset 0x14).
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   addr, wr_en, rd_en  byte address and access strobes from the core
//   wr_data, rd_data    store data in, combinational load data out
//   hit                 addr falls inside this block's window
//   sw_in, btn_in       raw asynchronous switch and button pins
//   led_out             LED register
//   irq                 registered |(edge & mask)
module mmio_gpio #(
    parameter logic [31:0] BASE_ADDR       = 32'h0002_0000,
    parameter int          SW_WIDTH        = 16,
    parameter int          BTN_WIDTH       = 5,
    parameter int          LED_WIDTH       = 16,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          addr,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [31:0]          wr_data,
    output logic [31:0]          rd_data,
    output logic                 hit,
    input  logic [SW_WIDTH-1:0]  sw_in,
    input  logic [BTN_WIDTH-1:0] btn_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] ID_VALUE = {16'h6710, 8'(SW_WIDTH), 8'(BTN_WIDTH)};

    localparam logic [4:0] OFF_ID     = 5'h00;
    localparam logic [4:0] OFF_SW     = 5'h04;
    localparam logic [4:0] OFF_BTNLED = 5'h08;
    localparam logic [4:0] OFF_EDGE   = 5'h0C;
    localparam logic [4:0] OFF_MASK   = 5'h10;
    localparam logic [4:0] OFF_TOGGLE = 5'h14;
    localparam logic [4:0] OFF_LED_RB = 5'h18;

    logic [SW_WIDTH-1:0]  sw_meta, sw_sync;
    logic [BTN_WIDTH-1:0] btn_meta, btn_sync;
    logic [BTN_WIDTH-1:0] btn_deb, btn_deb_next;
    logic [BTN_WIDTH-1:0] edge_q, mask_q, w1c;
    logic [CNT_W-1:0]     cnt_q    [BTN_WIDTH];
    logic [CNT_W-1:0]     cnt_next [BTN_WIDTH];
    logic [LED_WIDTH-1:0] led_q;
    logic                 irq_q;
    logic                 aligned, acc_wr, acc_rd;
    logic                 unused_bits;

    assign hit     = (addr[31:5] == BASE_ADDR[31:5]);
    assign aligned = (addr[1:0] == 2'b00);
    assign acc_wr  = hit & wr_en & aligned;
    assign acc_rd  = hit & rd_en & aligned;

    assign led_out = led_q;
    assign irq     = irq_q;

    // Upper store-data bits are legitimately ignored for narrow registers.
    assign unused_bits = ^wr_data;

    // Debounce: count consecutive cycles where the synchronised pin disagrees
    // with the debounced value; any agreement restarts the count, so the
    // counter never exceeds CNT_MAX and cannot wrap.
    always_comb begin
        btn_deb_next = btn_deb;
        for (int i = 0; i < BTN_WIDTH; i++) begin
            cnt_next[i] = '0;
            if (btn_sync[i] != btn_deb[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    btn_deb_next[i] = btn_sync[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w1c = (acc_wr && addr[4:0] == OFF_EDGE) ? wr_data[BTN_WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
            btn_deb  <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            led_q    <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < BTN_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sw_meta  <= sw_in;
            sw_sync  <= sw_meta;
            btn_meta <= btn_in;
            btn_sync <= btn_meta;
            btn_deb  <= btn_deb_next;
            for (int i = 0; i < BTN_WIDTH; i++) begin
                cnt_q[i] <= cnt_next[i];
            end
            // A new rising edge is OR-ed in after the clear, so set beats W1C.
            edge_q <= (edge_q & ~w1c) | (btn_deb_next & ~btn_deb);
            irq_q  <= |(edge_q & mask_q);
            if (acc_wr) begin
                case (addr[4:0])
                    OFF_BTNLED: led_q  <= wr_data[LED_WIDTH-1:0];
                    OFF_MASK:   mask_q <= wr_data[BTN_WIDTH-1:0];
`ifdef GPIO_LED_TOGGLE_EN
                    OFF_TOGGLE: led_q  <= led_q ^ wr_data[LED_WIDTH-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (acc_rd) begin
            case (addr[4:0])
                OFF_ID:     rd_data = ID_VALUE;
                OFF_SW:     rd_data = 32'(sw_sync);
                OFF_BTNLED: rd_data = 32'(btn_deb);
                OFF_EDGE:   rd_data = 32'(edge_q);
                OFF_MASK:   rd_data = 32'(mask_q);
                OFF_LED_RB: rd_data = 32'(led_q);
                default:    rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_gpio.sv
// tb/tb_mmio_gpio.sv - self-checking bench for mmio_gpio with a window-based reference model
module tb_mmio_gpio;

    localparam logic [31:0] BASE = 32'h0002_0000;
    localparam int          DC   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        wr_en, rd_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        hit;
    logic [15:0] sw_in;
    logic [4:0]  btn_in;
    logic [15:0] led_out;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    mmio_gpio #(
        .BASE_ADDR      (BASE),
        .SW_WIDTH       (16),
        .BTN_WIDTH      (5),
        .LED_WIDTH      (16),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .hit    (hit),
        .sw_in  (sw_in),
        .btn_in (btn_in),
        .led_out(led_out),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Reference model: pin history arrays; a button flips when the last DC
    // synchronised samples all disagree with its debounced value.
    logic [4:0]  bh [0:DC];
    logic [15:0] swh [0:1];
    logic [4:0]  m_deb, m_edge, m_mask;
    logic [15:0] m_led;
    logic        m_irq;
    logic        model_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [4:0] nd;
        logic [4:0] clr;
        logic       wr;
        logic       all_dis;
        if (!rst_n) begin
            m_deb  <= '0;
            m_edge <= '0;
            m_mask <= '0;
            m_led  <= '0;
            m_irq  <= 1'b0;
            for (int k = 0; k <= DC; k++) bh[k] <= '0;
            swh[0] <= '0;
            swh[1] <= '0;
        end else begin
            nd = m_deb;
            for (int i = 0; i < 5; i++) begin
                all_dis = 1'b1;
                for (int k = 1; k <= DC; k++) if (bh[k][i] == m_deb[i]) all_dis = 1'b0;
                if (all_dis) nd[i] = ~m_deb[i];
            end
            wr  = wr_en && (addr[31:5] == BASE[31:5]) && (addr[1:0] == 2'b00);
            clr = (wr && addr[4:0] == 5'h0C) ? wr_data[4:0] : 5'h0;
            m_irq  <= |(m_edge & m_mask);
            m_edge <= (m_edge & ~clr) | (nd & ~m_deb);
            m_deb  <= nd;
            if (wr && addr[4:0] == 5'h10) m_mask <= wr_data[4:0];
            if (wr && addr[4:0] == 5'h08) m_led <= wr_data[15:0];
`ifdef GPIO_LED_TOGGLE_EN
            if (wr && addr[4:0] == 5'h14) m_led <= m_led ^ wr_data[15:0];
`endif
            bh[0] <= btn_in;
            for (int k = 1; k <= DC; k++) bh[k] <= bh[k-1];
            swh[0] <= sw_in;
            swh[1] <= swh[0];
        end
        model_valid <= 1'b1;
    end

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic re);
        if (!re || a[31:5] != BASE[31:5] || a[1:0] != 2'b00) return 32'h0;
        case (a[4:0])
            5'h00:   return 32'h6710_1005;
            5'h04:   return {16'h0, swh[1]};
            5'h08:   return {27'h0, m_deb};
            5'h0C:   return {27'h0, m_edge};
            5'h10:   return {27'h0, m_mask};
            5'h18:   return {16'h0, m_led};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_led_out", {16'h0, led_out}, {16'h0, m_led});
            chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
            chk("model_hit", {31'h0, hit}, {31'h0, (addr[31:5] == BASE[31:5])});
            chk("model_rd_data", rd_data, m_read(addr, rd_en));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        rd_en   = 1'b0;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        chk(name, rd_data, exp);
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        addr    = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        sw_in   = '0;
        btn_in  = 5'h1F;

        // Reset and ID
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_led_out", {16'h0, led_out}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        read_chk("id_reg", BASE, 32'h6710_1005);
        read_chk("btn_before_debounce", BASE + 32'h08, 32'h0);
        repeat (6) tick();
        read_chk("btn_after_debounce", BASE + 32'h08, 32'h1F);
        btn_in = 5'h00;
        repeat (8) tick();
        bus_write(BASE + 32'h0C, 32'h1F);
        read_chk("edge_cleared", BASE + 32'h0C, 32'h0);

        // Map compatibility
        sw_in = 16'hA5C3;
        tick();
        tick();
        read_chk("switch_read", BASE + 32'h04, 32'h0000_A5C3);
        bus_write(BASE + 32'h08, 32'hFFFF_1234);
        chk("led_write", {16'h0, led_out}, 32'h1234);
        read_chk("led_readback", BASE + 32'h18, 32'h1234);

        // Debounce: short glitch is filtered, long press propagates at 2+4 cycles
        btn_in = 5'h04;
        repeat (3) tick();
        btn_in = 5'h00;
        repeat (8) tick();
        read_chk("glitch_btn", BASE + 32'h08, 32'h0);
        read_chk("glitch_edge", BASE + 32'h0C, 32'h0);
        btn_in = 5'h04;
        repeat (5) tick();
        read_chk("btn_at_5_cycles", BASE + 32'h08, 32'h0);
        read_chk("btn_at_6_cycles", BASE + 32'h08, 32'h04);
        read_chk("edge_after_press", BASE + 32'h0C, 32'h04);

        // Interrupt
        bus_write(BASE + 32'h10, 32'h04);
        chk("irq_same_cycle_as_mask", {31'h0, irq}, 32'h0);
        tick();
        chk("irq_asserted", {31'h0, irq}, 32'h1);
        bus_write(BASE + 32'h0C, 32'h04);
        chk("irq_held_after_w1c", {31'h0, irq}, 32'h1);
        tick();
        chk("irq_dropped", {31'h0, irq}, 32'h0);
        read_chk("edge_after_w1c", BASE + 32'h0C, 32'h0);

        // Collision: W1C of bit0 lands on the edge where debounced btn0 rises
        btn_in = 5'h05;
        repeat (5) tick();
        bus_write(BASE + 32'h0C, 32'h01);
        read_chk("edge_set_wins", BASE + 32'h0C, 32'h01);
        bus_write(BASE + 32'h0002_0009 - BASE + BASE - BASE, 32'hFFFF_FFFF);
        chk("unaligned_write_led", {16'h0, led_out}, 32'h1234);
        read_chk("unaligned_write_mask", BASE + 32'h10, 32'h04);
        addr  = 32'h0002_0009;
        rd_en = 1'b1;
        @(negedge clk);
        chk("unaligned_hit", {31'h0, hit}, 32'h1);
        chk("unaligned_rd_data", rd_data, 32'h0);
        tick();
        rd_en = 1'b0;

        // LED toggle
        bus_write(BASE + 32'h08, 32'h0000_00FF);
        bus_write(BASE + 32'h14, 32'h0000_0F0F);
`ifdef GPIO_LED_TOGGLE_EN
        chk("led_toggle", {16'h0, led_out}, 32'h0FF0);
`else
        chk("led_toggle_absent", {16'h0, led_out}, 32'h00FF);
`endif
        read_chk("toggle_reads_zero", BASE + 32'h14, 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: addr = BASE | (32'($urandom_range(0, 7)) << 2);
                7:                   addr = BASE | 32'($urandom_range(0, 31));
                8:                   addr = BASE + 32'h20 + 32'($urandom_range(0, 255));
                default:             addr = $urandom();
            endcase
            wr_en   = ($urandom_range(0, 3) == 0);
            rd_en   = $urandom_range(0, 1) == 1;
            wr_data = $urandom();
            if ($urandom_range(0, 5) == 0) btn_in = btn_in ^ (5'h01 << $urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) sw_in = 16'($urandom());
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_gpio.md
Name: mmio_gpio

Overview:
Parametrised memory-mapped GPIO peripheral on the processor's data bus, decoded alongside data memory.
- Inputs: synchronised switches; synchronised and debounced buttons, with sticky rising-edge capture.
- Outputs: registered LED port and a maskable interrupt request.
- Preserves the existing map: switches at BASE+0x04, buttons/LEDs at BASE+0x08.

Parameters:
BASE_ADDR, 32'h0002_0000, block base address; 32-byte aligned
SW_WIDTH, 16, switch inputs (1..32)
BTN_WIDTH, 5, button inputs (1..32)
LED_WIDTH, 16, LED outputs (1..32)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a debounced button changes (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
addr  in  32  byte address (ALU output)
wr_en  in  1  store strobe
rd_en  in  1  load strobe
wr_data  in  32  store data (rs2 value)
rd_data  out  32  read data, combinational
hit  out  1  addr inside block window
sw_in  in  SW_WIDTH  raw switches, asynchronous
btn_in  in  BTN_WIDTH  raw buttons, asynchronous
led_out  out  LED_WIDTH  LED register
irq  out  1  |(edge & mask), registered

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled only on the clk rising edge.
- Reset values: led_out=0, irq=0, edge=0, mask=0, debounced=0, debounce counters=0, all sync flops=0. A reset mid-debounce discards any partial count.
- Decode:
  - hit=1 iff addr[31:5]==BASE_ADDR[31:5].
  - Access is word-only; size is ignored.
  - Offsets with addr[1:0]!=0, or unmapped offsets, read 0 and ignore writes.
- Register map (offset: access, function):
  - 0x00: RO, {16'h6710, 8'(SW_WIDTH), 8'(BTN_WIDTH)} ID.
  - 0x04: RO, synchronised switches, zero-extended.
  - 0x08: read returns debounced buttons, zero-extended; write sets led_out <= wr_data[LED_WIDTH-1:0].
  - 0x0C: EDGE, sticky rising-edge flags; write-1-to-clear.
  - 0x10: MASK, RW, BTN_WIDTH bits; irq enable.
  - 0x14: LED_TOGGLE (optional feature below).
  - 0x18: LED readback, RO.
- Read timing: rd_data is valid in the same cycle as addr, from current register state. rd_data=0 when hit=0 or rd_en=0.
- Write timing: a write is committed on the clk edge where hit & wr_en. The new value is visible on reads and led_out the following cycle.
- Synchronisers: two flops per input bit. Switch value readable 2 cycles after the pin changes.
- Debounce, per button:
  - While sync != debounced, the counter increments; it resets to 0 whenever sync == debounced.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still != debounced, debounced <= sync and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never propagate.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it must not wrap.
- Edge capture: edge[i] is set on the cycle debounced[i] transitions 0->1. Falling edges do not set it.
- EDGE write/set collision: set wins when a W1C to bit i coincides with a new edge on bit i. Writing 0 bits has no effect.
- irq: irq <= |(edge & mask), one cycle after edge/mask change. Clearing the last pending masked bit drops irq on the next cycle.
- Unused upper bits of every register read as 0.

Optional Feature:
GPIO_LED_TOGGLE_EN
- Defined: a write to 0x14 sets led_out <= led_out ^ wr_data[LED_WIDTH-1:0]. Reads of 0x14 return 0. A write to 0x08 and a write to 0x14 never occur in the same cycle (single bus).
- Undefined: 0x14 is unmapped (reads 0, writes ignored). ID bit [31] is 0 either way; the feature is detected by write-then-readback via 0x18.

Test Plan (bench parameters: DEBOUNCE_CYCLES=4, defaults otherwise):
1. Reset/ID: hold rst_n=0 for 3 cycles with btn_in=5'h1F, then release -> led_out=0, irq=0, read 0x0002_0000 = 32'h6710_1005, read 0x08 = 0 until debounce completes.
2. Map compatibility: sw_in=16'hA5C3, wait 2 cycles, read 0x0002_0004 -> 32'h0000_A5C3. Write 0x0002_0008 with 32'hFFFF_1234 -> led_out=16'h1234 next cycle; 0x18 reads 32'h1234.
3. Debounce: pulse btn_in[2] high for 3 cycles -> 0x08 stays 0, EDGE=0. Hold high 6 cycles -> 0x08 reads 32'h04 exactly 2+4 cycles after the rise; EDGE=32'h04.
4. Interrupt: with EDGE=32'h04, write MASK=32'h04 -> irq=1 one cycle later. Write EDGE=32'h04 (W1C) -> EDGE=0, irq=0 next cycle.
5. Collision: debounced btn0 rises on the same edge as a W1C of EDGE bit0 -> EDGE[0]=1 afterwards. Unaligned write to 0x0002_0009 -> no state change; hit=1, rd_data=0.
6. Toggle (macro on): led_out=16'h00FF, write 0x14 with 32'h0F0F -> led_out=16'h0FF0. With the macro off -> led_out unchanged at 16'h00FF.
